// File: rtl/frame_gen_pkg.sv
// Shared types and constants for the frame pattern generator.
package frame_gen_pkg;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // log2 of the checkerboard square size in pixels
  localparam int CHECKER_SHIFT = 3;

endpackage

// File: rtl/frame_pattern_pixel.sv
// One pixel of the selected test pattern at (col,row); purely combinational.
module frame_pattern_pixel
  import frame_gen_pkg::*;
#(
  parameter int NUMPIXELPLANES = 3,
  parameter int BITS_PER_PLANE = 8,
  parameter int DIMBITS        = 13
) (
  input  pattern_e                                  pattern,
  input  logic [DIMBITS-1:0]                        col,
  input  logic [DIMBITS-1:0]                        row,
  input  logic [DIMBITS-1:0]                        quarterWidth,
  input  logic [NUMPIXELPLANES*BITS_PER_PLANE-1:0]  solidColor,
  output logic [NUMPIXELPLANES*BITS_PER_PLANE-1:0]  pixel
);

  logic [DIMBITS:0] colX, q1, q2, q3;
  logic unusedRow;

  // only one row bit drives the checkerboard
  assign unusedRow = ^row;

  always_comb begin
    colX  = {1'b0, col};
    q1    = {1'b0, quarterWidth};
    q2    = q1 << 1;
    q3    = q2 + q1;
    pixel = '0;
    case (pattern)
      PAT_BARS: begin
        if (colX < q1)      pixel[0 +: BITS_PER_PLANE] = '1;
        else if (colX < q2) pixel[BITS_PER_PLANE +: BITS_PER_PLANE] = '1;
        else if (colX < q3) pixel[2*BITS_PER_PLANE +: BITS_PER_PLANE] = '1;
        else                pixel = '1;
      end
      PAT_RAMP: begin
        for (int k = 0; k < NUMPIXELPLANES; k++)
          pixel[k*BITS_PER_PLANE +: BITS_PER_PLANE] = col[BITS_PER_PLANE-1:0];
      end
      PAT_CHECKER: begin
        if (col[CHECKER_SHIFT] ^ row[CHECKER_SHIFT]) pixel = '1;
      end
      PAT_SOLID: pixel = solidColor;
      default:   pixel = '0;
    endcase
  end

endmodule

// File: rtl/frame_pattern_generator.sv
// Raster test-pattern source on a valid/ready/last stream; config latched per frame,
// first beat one cycle after start, frames back-to-back while enabled.
module frame_pattern_generator
  import frame_gen_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = 1,
  parameter int NUMPIXELPLANES  = 3,
  parameter int BITS_PER_PLANE  = 8,
  parameter int DIMBITS         = 13
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  enable,
  input  logic [1:0]                                            patternSel,
  input  logic [DIMBITS-1:0]                                    frameWidth,
  input  logic [DIMBITS-1:0]                                    frameHeight,
  input  logic [NUMPIXELPLANES*BITS_PER_PLANE-1:0]              solidColor,
  output logic [PIXELS_PER_BEAT*NUMPIXELPLANES*BITS_PER_PLANE-1:0] dataOut,
  output logic                                                  dataOutValid,
  input  logic                                                  dataOutReady,
  output logic                                                  dataOutLast,
  output logic                                                  dataOutUser,
  output logic                                                  frameDone,
  output logic                                                  busy,
  output logic                                                  configError
);

  localparam int PIXW = NUMPIXELPLANES * BITS_PER_PLANE;
  localparam logic [DIMBITS-1:0] PPB_D = DIMBITS'(PIXELS_PER_BEAT);
  localparam logic [DIMBITS-1:0] ONE_D = DIMBITS'(1);

  state_e              state;
  logic [DIMBITS-1:0]  col, row;
  logic [DIMBITS-1:0]  cfgWidth, cfgHeight;
  pattern_e            cfgPattern;
  logic [PIXW-1:0]     cfgSolid;

  logic [DIMBITS-1:0]  effWidth;
  logic                cfgValid, xfer, lastBeat, lastRow, frameEnd;
  logic                restart, startNow, advance, genLast;
  logic [DIMBITS-1:0]  genCol, genRow, genWidth;
  pattern_e            genPattern;
  logic [PIXW-1:0]     genSolid;
  logic [PIXELS_PER_BEAT*PIXW-1:0] pixBeat;

  assign effWidth = frameWidth & ~(PPB_D - ONE_D);
  assign cfgValid = (effWidth != '0) && (frameHeight != '0);
  assign xfer     = dataOutValid && dataOutReady;
  assign lastBeat = (col + PPB_D) == cfgWidth;
  assign lastRow  = (row + ONE_D) == cfgHeight;
  assign frameEnd = xfer && lastBeat && lastRow;

  // A start attempt happens from IDLE, or at the end of a frame while still enabled
  assign restart  = ((state == IDLE) && enable) || ((state == RUN) && frameEnd && enable);
  assign startNow = restart && cfgValid;
  assign advance  = startNow || (xfer && !frameEnd);

  // Next beat to present: origin of a new frame with fresh config, else the successor position
  assign genWidth   = startNow ? effWidth : cfgWidth;
  assign genPattern = startNow ? pattern_e'(patternSel) : cfgPattern;
  assign genSolid   = startNow ? solidColor : cfgSolid;
  assign genCol     = (startNow || lastBeat) ? '0 : col + PPB_D;
  assign genRow     = startNow ? '0 : (lastBeat ? row + ONE_D : row);
  assign genLast    = (genCol + PPB_D) == genWidth;

  for (genvar p = 0; p < PIXELS_PER_BEAT; p++) begin : gPixel
    frame_pattern_pixel #(
      .NUMPIXELPLANES (NUMPIXELPLANES),
      .BITS_PER_PLANE (BITS_PER_PLANE),
      .DIMBITS        (DIMBITS)
    ) uPixel (
      .pattern      (genPattern),
      .col          (genCol + DIMBITS'(p)),
      .row          (genRow),
      .quarterWidth (genWidth >> 2),
      .solidColor   (genSolid),
      .pixel        (pixBeat[p*PIXW +: PIXW])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      cfgWidth     <= '0;
      cfgHeight    <= '0;
      cfgPattern   <= PAT_BARS;
      cfgSolid     <= '0;
      dataOut      <= '0;
      dataOutValid <= 1'b0;
      dataOutLast  <= 1'b0;
      dataOutUser  <= 1'b0;
      frameDone    <= 1'b0;
      busy         <= 1'b0;
      configError  <= 1'b0;
    end else begin
      frameDone <= frameEnd;
      if (restart) configError <= !cfgValid;

      if (startNow) begin
        cfgWidth   <= effWidth;
        cfgHeight  <= frameHeight;
        cfgPattern <= pattern_e'(patternSel);
        cfgSolid   <= solidColor;
      end

      if (advance) begin
        col          <= genCol;
        row          <= genRow;
        dataOut      <= pixBeat;
        dataOutLast  <= genLast;
        dataOutUser  <= startNow;
        dataOutValid <= 1'b1;
      end else if (xfer) begin
        dataOutValid <= 1'b0;
        dataOutLast  <= 1'b0;
        dataOutUser  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (startNow) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (frameEnd && !startNow) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!enable && !frameEnd) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (frameEnd) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
